// File: rtl/qslave2908_pkg.sv
// ---------------------------------------------------------------------------
// qslave2908_pkg
//  Shared constants for the QBUS slave sequencer: one-hot state encodings,
//  the default I/O-page offset of the register window, the data-settle
//  timer width and the byte-lane helper used on writes.
// ---------------------------------------------------------------------------
package qslave2908_pkg;

  // I/O-page offset of register 0 (bus address 17772150).
  localparam logic [12:0] QBUS_BASE_DEFAULT = 13'o12150;

  // Width of the DAL-settle timer that runs between assert_data and DALst.
  localparam int TIMER_W = 4;

  // One-hot sequencer states.
  localparam int ST_W = 9;
  localparam logic [ST_W-1:0] ST_IDLE      = 9'b000000001;
  localparam logic [ST_W-1:0] ST_DECODE    = 9'b000000010;
  localparam logic [ST_W-1:0] ST_ADDRESSED = 9'b000000100;
  localparam logic [ST_W-1:0] ST_RD_SETUP  = 9'b000001000;
  localparam logic [ST_W-1:0] ST_RD_STROBE = 9'b000010000;
  localparam logic [ST_W-1:0] ST_RD_HOLD   = 9'b000100000;
  localparam logic [ST_W-1:0] ST_WR_RPLY   = 9'b001000000;
  localparam logic [ST_W-1:0] ST_WR_HOLD   = 9'b010000000;
  localparam logic [ST_W-1:0] ST_SYNC_CLR  = 9'b100000000;

  // Write byte lanes {hi,lo}: WTBT in the data phase marks a byte write,
  // and the latched address bit 0 picks the lane.
  function automatic logic [1:0] lane_mask(input logic wtbt, input logic a0);
    if (!wtbt) return 2'b11;
    return a0 ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/qslave2908_sync2.sv
// ---------------------------------------------------------------------------
// sync2
//  Two-flop synchronizer with asynchronous clear, one per bus input.
//  Ports:
//    clk    in  1  sampling clock
//    rst_n  in  1  asynchronous active-low clear
//    d_i    in  1  asynchronous input
//    q_o    out 1  synchronized output (two clk of latency)
// ---------------------------------------------------------------------------
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/qslave2908.sv
// ---------------------------------------------------------------------------
// qslave2908
//  QBUS slave sequencer for boards with Am2908 transceivers. Decodes
//  DATI/DATO/DATOB/DATIO cycles aimed at the I/O-page register window,
//  sequences the Am2908 strobe/enable, answers with TRPLY and gives the
//  register file one-cycle read/write strobes.
//  Ports:
//    clk, reset_n                 20 MHz clock, async active-low reset
//    RSYNC RDIN RDOUT RWTBT RBS7  bus controls (async to clk)
//    RINIT                        bus INIT (async to clk)
//    RDAL[21:0]                   DAL as received from the Am2908s
//    TRPLY                        bus RPLY
//    DALst, DALbe                 Am2908 clock strobe / bus enable
//    assert_data                  register file drives read data
//    reg_sel, reg_rd, reg_wr      register index and one-cycle strobes
//    byte_en[1:0]                 write byte lanes {hi,lo}
//    selected                     current cycle addresses us
// ---------------------------------------------------------------------------
module qslave2908
  import qslave2908_pkg::*;
#(
  parameter logic [12:0] BASE_ADDR = QBUS_BASE_DEFAULT,
  parameter int          REG_BITS  = 1,
  parameter int          DATA_DLY  = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                RSYNC,
  input  logic                RDIN,
  input  logic                RDOUT,
  input  logic                RWTBT,
  input  logic                RBS7,
  input  logic                RINIT,
  input  logic [21:0]         RDAL,
  output logic                TRPLY,
  output logic                DALst,
  output logic                DALbe,
  output logic                assert_data,
  output logic [REG_BITS-1:0] reg_sel,
  output logic                reg_rd,
  output logic                reg_wr,
  output logic [1:0]          byte_en,
  output logic                selected
);

  localparam logic [TIMER_W-1:0] DLY = TIMER_W'(DATA_DLY);

  // Synchronized bus controls.
  logic s_rsync, s_rdin, s_rdout, s_rwtbt, s_rinit;

  sync2 u_sync_rsync (.clk(clk), .rst_n(reset_n), .d_i(RSYNC), .q_o(s_rsync));
  sync2 u_sync_rdin  (.clk(clk), .rst_n(reset_n), .d_i(RDIN),  .q_o(s_rdin));
  sync2 u_sync_rdout (.clk(clk), .rst_n(reset_n), .d_i(RDOUT), .q_o(s_rdout));
  sync2 u_sync_rwtbt (.clk(clk), .rst_n(reset_n), .d_i(RWTBT), .q_o(s_rwtbt));
  sync2 u_sync_rinit (.clk(clk), .rst_n(reset_n), .d_i(RINIT), .q_o(s_rinit));

  // Address latch clocked by the SYNC rising edge: DAL carries the address
  // only around that edge, long before the clk-domain copy of SYNC arrives.
  logic [12:0] addr_q;
  logic        bs7_q;

  always_ff @(posedge RSYNC or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
      bs7_q  <= 1'b0;
    end else begin
      addr_q <= RDAL[12:0];
      bs7_q  <= RBS7;
    end
  end

  // Only the I/O-page offset matters to the decoder; the upper DAL bits
  // belong to the data path.
  logic unused_rdal;
  assign unused_rdal = ^RDAL[21:13];

  logic match;
  assign match = bs7_q && (addr_q[12:REG_BITS+1] == BASE_ADDR[12:REG_BITS+1]);

  // Sequencer state and registered outputs.
  logic [ST_W-1:0]     state_q,    state_d;
  logic [TIMER_W-1:0]  timer_q,    timer_d;
  logic                trply_q,    trply_d;
  logic                dalst_q,    dalst_d;
  logic                dalbe_q,    dalbe_d;
  logic                assert_q,   assert_d;
  logic                selected_q, selected_d;
  logic [REG_BITS-1:0] reg_sel_q,  reg_sel_d;
  logic                reg_rd_q,   reg_rd_d;
  logic                reg_wr_q,   reg_wr_d;
  logic [1:0]          byte_en_q,  byte_en_d;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would infer a latch.
    state_d    = state_q;
    timer_d    = timer_q;
    trply_d    = trply_q;
    dalst_d    = dalst_q;
    dalbe_d    = dalbe_q;
    assert_d   = assert_q;
    selected_d = selected_q;
    reg_sel_d  = reg_sel_q;
    reg_rd_d   = 1'b0;
    reg_wr_d   = 1'b0;
    byte_en_d  = 2'b00;

    case (state_q)
      ST_IDLE: begin
        if (s_rsync) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (match) begin
          selected_d = 1'b1;
          reg_sel_d  = addr_q[REG_BITS:1];
          state_d    = ST_ADDRESSED;
        end else begin
          state_d = ST_SYNC_CLR;
        end
      end
      ST_ADDRESSED: begin
        // DIN has priority over DOUT if both are seen together.
        if (s_rdin) begin
          reg_rd_d = 1'b1;
          assert_d = 1'b1;
          timer_d  = DLY;
          state_d  = ST_RD_SETUP;
        end else if (s_rdout) begin
          reg_wr_d  = 1'b1;
          byte_en_d = lane_mask(s_rwtbt, addr_q[0]);
          state_d   = ST_WR_RPLY;
        end else if (!s_rsync) begin
          selected_d = 1'b0;
          reg_sel_d  = '0;
          state_d    = ST_IDLE;
        end
      end
      ST_RD_SETUP: begin
        // Give the ribbon cable time to settle before clocking the Am2908s.
        if (timer_q == '0) begin
          dalst_d = 1'b1;
          dalbe_d = 1'b1;
          state_d = ST_RD_STROBE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_RD_STROBE: begin
        dalst_d = 1'b0;
        trply_d = 1'b1;
        state_d = ST_RD_HOLD;
      end
      ST_RD_HOLD: begin
        // Return to ADDRESSED so a DOUT may follow in the same SYNC (DATIO).
        if (!s_rdin) begin
          trply_d  = 1'b0;
          dalbe_d  = 1'b0;
          assert_d = 1'b0;
          state_d  = ST_ADDRESSED;
        end
      end
      ST_WR_RPLY: begin
        trply_d = 1'b1;
        state_d = ST_WR_HOLD;
      end
      ST_WR_HOLD: begin
        if (!s_rdout) begin
          trply_d = 1'b0;
          state_d = ST_ADDRESSED;
        end
      end
      ST_SYNC_CLR: begin
        if (!s_rsync) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Bus INIT aborts whatever is in flight.
    if (s_rinit) begin
      state_d    = ST_IDLE;
      timer_d    = '0;
      trply_d    = 1'b0;
      dalst_d    = 1'b0;
      dalbe_d    = 1'b0;
      assert_d   = 1'b0;
      selected_d = 1'b0;
      reg_sel_d  = '0;
      reg_rd_d   = 1'b0;
      reg_wr_d   = 1'b0;
      byte_en_d  = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      trply_q    <= 1'b0;
      dalst_q    <= 1'b0;
      dalbe_q    <= 1'b0;
      assert_q   <= 1'b0;
      selected_q <= 1'b0;
      reg_sel_q  <= '0;
      reg_rd_q   <= 1'b0;
      reg_wr_q   <= 1'b0;
      byte_en_q  <= 2'b00;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      trply_q    <= trply_d;
      dalst_q    <= dalst_d;
      dalbe_q    <= dalbe_d;
      assert_q   <= assert_d;
      selected_q <= selected_d;
      reg_sel_q  <= reg_sel_d;
      reg_rd_q   <= reg_rd_d;
      reg_wr_q   <= reg_wr_d;
      byte_en_q  <= byte_en_d;
    end
  end

  assign TRPLY       = trply_q;
  assign DALst       = dalst_q;
  assign DALbe       = dalbe_q;
  assign assert_data = assert_q;
  assign selected    = selected_q;
  assign reg_sel     = reg_sel_q;
  assign reg_rd      = reg_rd_q;
  assign reg_wr      = reg_wr_q;
  assign byte_en     = byte_en_q;

endmodule

// File: tb/tb_qslave2908.sv
// ---------------------------------------------------------------------------
// tb_qslave2908
//  Directed bench for the QBUS slave sequencer: DATI, DATOB, DATIO,
//  simultaneous DIN/DOUT, non-matching addresses, INIT abort and async reset.
//  Inputs change and outputs are checked on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_qslave2908;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        RSYNC = 1'b0, RDIN = 1'b0, RDOUT = 1'b0, RWTBT = 1'b0;
  logic        RBS7 = 1'b0, RINIT = 1'b0;
  logic [21:0] RDAL = '0;
  logic        TRPLY, DALst, DALbe, assert_data, reg_rd, reg_wr, selected;
  logic [0:0]  reg_sel;
  logic [1:0]  byte_en;

  always #25 clk = ~clk;

  qslave2908 dut (
    .clk(clk), .reset_n(reset_n),
    .RSYNC(RSYNC), .RDIN(RDIN), .RDOUT(RDOUT), .RWTBT(RWTBT),
    .RBS7(RBS7), .RINIT(RINIT), .RDAL(RDAL),
    .TRPLY(TRPLY), .DALst(DALst), .DALbe(DALbe), .assert_data(assert_data),
    .reg_sel(reg_sel), .reg_rd(reg_rd), .reg_wr(reg_wr),
    .byte_en(byte_en), .selected(selected)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] outs();
    return {TRPLY, DALst, DALbe, assert_data, reg_sel, reg_rd, reg_wr, byte_en, selected};
  endfunction

  // Event monitor, sampled mid-high-phase so falling-edge checks see settled counts.
  int         rd_cnt = 0, wr_cnt = 0, rply_rise = 0, dalbe_cyc = 0, sel_cyc = 0;
  logic       prev_rply = 1'b0, prev_dalbe = 1'b0, dalbe_before_rply = 1'b0;
  logic [1:0] wr_be = 2'b00;
  logic       wr_sel = 1'b0;

  always @(posedge clk) begin
    #10;
    if (reg_rd) rd_cnt++;
    if (reg_wr) begin
      wr_cnt++;
      wr_be  = byte_en;
      wr_sel = reg_sel[0];
    end
    if (DALbe) dalbe_cyc++;
    if (selected) sel_cyc++;
    if (TRPLY && !prev_rply) begin
      rply_rise++;
      dalbe_before_rply = prev_dalbe;
    end
    prev_rply  = TRPLY;
    prev_dalbe = DALbe;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rply(input logic lvl, input int budget, output int n);
    n = 0;
    while (TRPLY !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_quiet(input int budget, output int n);
    n = 0;
    while (outs() !== 10'd0 && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic start_cycle(input logic [21:0] addr, input logic bs7);
    RDAL = addr;
    RBS7 = bs7;
    @(negedge clk);
    RSYNC = 1'b1;
    tick(5);
    RDAL = 22'o123456;
  endtask

  task automatic end_cycle();
    RSYNC = 1'b0;
    RWTBT = 1'b0;
    tick(5);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rd0, wr0, rr0, db0, sc0;

    tick(2);
    check("reset_outs", {22'd0, outs()}, 32'd0);
    reset_n = 1'b1;
    tick(2);

    // DATI to 17772150: read latency is 2 sync + 3 + DATA_DLY = 6 clk.
    rd0 = rd_cnt;
    start_cycle(22'o17772150, 1'b1);
    check("dati_selected", {31'd0, selected}, 32'd1);
    check("dati_reg_sel", {31'd0, reg_sel}, 32'd0);
    RDIN = 1'b1;
    wait_rply(1'b1, 12, n);
    check("dati_rply_latency", n, 6);
    check("dati_dalbe_at_rply", {31'd0, DALbe}, 32'd1);
    check("dati_dalbe_before_rply", {31'd0, dalbe_before_rply}, 32'd1);
    check("dati_assert_data", {31'd0, assert_data}, 32'd1);
    check("dati_one_reg_rd", rd_cnt - rd0, 1);
    RDIN = 1'b0;
    wait_rply(1'b0, 8, n);
    check("dati_rply_release", n, 3);
    check("dati_released", {29'd0, DALbe, assert_data, DALst}, 32'd0);
    end_cycle();
    check("dati_deselect", {31'd0, selected}, 32'd0);

    // DATOB to 17772153, high byte of register 1.
    wr0 = wr_cnt;
    start_cycle(22'o17772153, 1'b1);
    RWTBT = 1'b1;
    RDOUT = 1'b1;
    wait_rply(1'b1, 12, n);
    check("datob_rply_latency", n, 4);
    check("datob_one_reg_wr", wr_cnt - wr0, 1);
    check("datob_reg_sel", {31'd0, wr_sel}, 32'd1);
    check("datob_byte_en", {30'd0, wr_be}, 32'd2);
    tick(5);
    check("datob_rply_held", {31'd0, TRPLY}, 32'd1);
    RDOUT = 1'b0;
    wait_rply(1'b0, 8, n);
    check("datob_rply_release", n, 3);
    end_cycle();

    // DATIO on register 0: read then word write inside one SYNC.
    rr0 = rply_rise; rd0 = rd_cnt; wr0 = wr_cnt;
    start_cycle(22'o17772150, 1'b1);
    RDIN = 1'b1;
    wait_rply(1'b1, 12, n);
    check("datio_read_latency", n, 6);
    RDIN = 1'b0;
    wait_rply(1'b0, 8, n);
    RDOUT = 1'b1;
    wait_rply(1'b1, 12, n);
    check("datio_write_latency", n, 4);
    RDOUT = 1'b0;
    wait_rply(1'b0, 8, n);
    check("datio_two_rplys", rply_rise - rr0, 2);
    check("datio_rd_wr", {(rd_cnt - rd0), (wr_cnt - wr0)} , {32'd1, 32'd1});
    check("datio_byte_en", {30'd0, wr_be}, 32'd3);
    check("datio_reg_sel", {31'd0, wr_sel}, 32'd0);
    end_cycle();

    // DIN and DOUT together: the read wins and TRPLY follows read timing.
    rd0 = rd_cnt; wr0 = wr_cnt;
    start_cycle(22'o17772152, 1'b1);
    RDIN = 1'b1;
    RDOUT = 1'b1;
    wait_rply(1'b1, 12, n);
    check("both_rply_latency", n, 6);
    check("both_read_only", {(rd_cnt - rd0), (wr_cnt - wr0)}, {32'd1, 32'd0});
    RDIN = 1'b0;
    RDOUT = 1'b0;
    wait_rply(1'b0, 8, n);
    check("both_rply_release", n, 3);
    end_cycle();

    // Outside the window (17772160) and a memory address (BS7=0).
    rr0 = rply_rise; db0 = dalbe_cyc; sc0 = sel_cyc; rd0 = rd_cnt;
    start_cycle(22'o17772160, 1'b1);
    RDIN = 1'b1;
    tick(10);
    RDIN = 1'b0;
    end_cycle();
    start_cycle(22'o00772150, 1'b0);
    RDIN = 1'b1;
    tick(10);
    RDIN = 1'b0;
    end_cycle();
    check("nomatch_no_rply", rply_rise - rr0, 0);
    check("nomatch_no_dalbe", dalbe_cyc - db0, 0);
    check("nomatch_not_selected", sel_cyc - sc0, 0);
    check("nomatch_no_reg_rd", rd_cnt - rd0, 0);

    // INIT mid-read while TRPLY is asserted, then a clean DATI.
    start_cycle(22'o17772150, 1'b1);
    RDIN = 1'b1;
    wait_rply(1'b1, 12, n);
    RINIT = 1'b1;
    wait_quiet(8, n);
    check("init_quiet_latency", n, 3);
    check("init_outs", {22'd0, outs()}, 32'd0);
    tick(2);
    RINIT = 1'b0;
    RDIN = 1'b0;
    RSYNC = 1'b0;
    tick(5);
    rd0 = rd_cnt;
    start_cycle(22'o17772150, 1'b1);
    RDIN = 1'b1;
    wait_rply(1'b1, 12, n);
    check("post_init_latency", n, 6);
    RDIN = 1'b0;
    wait_rply(1'b0, 8, n);
    check("post_init_reg_rd", rd_cnt - rd0, 1);
    end_cycle();

    // Async reset during WR_HOLD.
    start_cycle(22'o17772150, 1'b1);
    RDOUT = 1'b1;
    wait_rply(1'b1, 12, n);
    tick(1);
    #5;
    reset_n = 1'b0;
    #1;
    check("reset_async_outs", {22'd0, outs()}, 32'd0);
    RDOUT = 1'b0;
    RSYNC = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(3);
    check("reset_idle_outs", {22'd0, outs()}, 32'd0);

    // Low-byte write to 17772152 after reset.
    wr0 = wr_cnt;
    start_cycle(22'o17772152, 1'b1);
    RWTBT = 1'b1;
    RDOUT = 1'b1;
    wait_rply(1'b1, 12, n);
    check("lowbyte_latency", n, 4);
    check("lowbyte_byte_en", {30'd0, wr_be}, 32'd1);
    check("lowbyte_reg_sel", {31'd0, wr_sel}, 32'd1);
    check("lowbyte_one_wr", wr_cnt - wr0, 1);
    RDOUT = 1'b0;
    wait_rply(1'b0, 8, n);
    end_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
